// File: rtl/nand_flash_responder_pkg.sv
// Shared opcodes and controller state encoding for the NAND flash responder.
package nand_pkg;

  localparam logic [7:0] CMD_READ      = 8'h00;
  localparam logic [7:0] CMD_PROG      = 8'h80;
  localparam logic [7:0] CMD_PROG_CONF = 8'h10;
  localparam logic [7:0] CMD_STATUS    = 8'h70;
  localparam logic [7:0] CMD_RESET     = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    DATA_IN   = 3'd2,
    BUSY_READ = 3'd3,
    BUSY_PROG = 3'd4,
    BUSY_RST  = 3'd5,
    DATA_OUT  = 3'd6,
    STATUS    = 3'd7
  } state_e;

endpackage

// File: rtl/nand_flash_responder_page_array.sv
// Flash cell array plus single page buffer; whole-page copies fire on the
// final busy count so an interrupted program never touches the array.
module nand_page_array #(
  parameter int unsigned PAGE_BYTES = 32,
  parameter int unsigned PAGES      = 64
) (
  input  logic                          clk,
  input  logic                          load,
  input  logic                          commit,
  input  logic [$clog2(PAGES)-1:0]      row,
  input  logic                          wr_en,
  input  logic [$clog2(PAGE_BYTES)-1:0] wr_col,
  input  logic [7:0]                    wr_data,
  input  logic [$clog2(PAGE_BYTES)-1:0] rd_col,
  output logic [7:0]                    rd_data_c
);

  localparam int unsigned PAGE_W = PAGE_BYTES * 8;

  // Erased flash reads 0xFF; contents survive rst.
  logic [PAGE_W-1:0] mem [PAGES] = '{default: '1};
  logic [PAGE_W-1:0] page_buf = '1;

  // Page copy engine and host byte writes into the buffer.
  always_ff @(posedge clk) begin
    if (load) begin
      page_buf <= mem[row];
    end else if (wr_en) begin
      page_buf[{wr_col, 3'b000} +: 8] <= wr_data;
    end
    if (commit) begin
      mem[row] <= page_buf;
    end
  end

  assign rd_data_c = page_buf[{rd_col, 3'b000} +: 8];

endmodule

// File: rtl/nand_flash_responder.sv
// NAND flash device responder: command/address/data decode, busy timing and
// bus turnaround. Optional READ STATUS (0x70) when NAND_STATUS_CMD_EN is defined.
module nand_flash_responder
  import nand_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = 32,
  parameter int unsigned PAGES      = 64,
  parameter int unsigned T_READ     = 8,
  parameter int unsigned T_PROG     = 16,
  parameter int unsigned T_RST      = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_REN,
  input  logic       F_WEN,
  output logic       F_RB
);

  localparam int unsigned COL_W = $clog2(PAGE_BYTES);
  localparam int unsigned ROW_W = $clog2(PAGES);
  localparam int unsigned T_MAX = (T_READ > T_PROG) ? ((T_READ > T_RST) ? T_READ : T_RST)
                                                    : ((T_PROG > T_RST) ? T_PROG : T_RST);
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

`ifdef NAND_STATUS_CMD_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, col_inc_c;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, t_last_c;
  logic               addr_hi_q, addr_hi_d;
  logic               prog_q, prog_d;
  logic               last_abort_q, last_abort_d;
  logic               rb_d;
  logic               wen_q, ren_q;
  logic               io_oe_q, io_oe_d;
  logic [7:0]         io_dout_q, io_dout_d;
  logic [7:0]         bus_c, buf_rd_c, status_c;
  logic               wstrobe_c, rfall_c, rrise_c, is_cmd_c, is_addr_c, is_data_c;
  logic               buf_we_c, load_c, commit_c;

  assign bus_c     = F_IO;
  assign wstrobe_c = ~wen_q & F_WEN;
  assign rfall_c   = ren_q & ~F_REN & ~wstrobe_c;
  assign rrise_c   = ~ren_q & F_REN & ~wstrobe_c;
  assign is_cmd_c  = wstrobe_c & F_CLE & ~F_ALE;
  assign is_addr_c = wstrobe_c & ~F_CLE & F_ALE;
  assign is_data_c = wstrobe_c & ~F_CLE & ~F_ALE;
  assign col_inc_c = (col_q == COL_W'(PAGE_BYTES - 1)) ? '0 : col_q + COL_W'(1);
  assign t_last_c  = (state_q == BUSY_READ) ? CNT_W'(T_READ - 1) :
                     (state_q == BUSY_PROG) ? CNT_W'(T_PROG - 1) : CNT_W'(T_RST - 1);
  assign status_c  = {F_RB, 1'b1, 4'b0000, last_abort_q, 1'b0};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, datapath updates and copy-engine strobes.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    addr_hi_d    = addr_hi_q;
    prog_d       = prog_q;
    last_abort_d = last_abort_q;
    rb_d         = F_RB;
    buf_we_c     = 1'b0;
    load_c       = 1'b0;
    commit_c     = 1'b0;
    case (state_q)
      IDLE, DATA_OUT, STATUS: begin
        if (is_cmd_c) begin
          if (bus_c == CMD_READ || bus_c == CMD_PROG) begin
            state_d   = ADDR;
            addr_hi_d = 1'b0;
            prog_d    = (bus_c == CMD_PROG);
          end else if (bus_c == CMD_RESET) begin
            state_d = BUSY_RST;
            cnt_d   = '0;
            rb_d    = 1'b0;
          end else if (STATUS_EN && bus_c == CMD_STATUS) begin
            state_d = STATUS;
          end else if (state_q == STATUS) begin
            state_d = IDLE;
          end
        end else if (state_q == DATA_OUT && rrise_c) begin
          col_d = col_inc_c;
        end
      end
      ADDR: begin
        if (is_cmd_c && bus_c == CMD_RESET) begin
          state_d = BUSY_RST;
          cnt_d   = '0;
          rb_d    = 1'b0;
        end else if (is_addr_c) begin
          if (!addr_hi_q) begin
            col_d     = COL_W'(32'(bus_c) % PAGE_BYTES);
            addr_hi_d = 1'b1;
          end else begin
            row_d = ROW_W'(32'(bus_c) % PAGES);
            cnt_d = '0;
            if (prog_q) begin
              state_d = DATA_IN;
            end else begin
              state_d = BUSY_READ;
              rb_d    = 1'b0;
            end
          end
        end
      end
      DATA_IN: begin
        if (is_data_c) begin
          buf_we_c = 1'b1;
          col_d    = col_inc_c;
        end else if (is_cmd_c) begin
          if (bus_c == CMD_PROG_CONF) begin
            state_d      = BUSY_PROG;
            cnt_d        = '0;
            rb_d         = 1'b0;
            last_abort_d = 1'b0;
          end else if (bus_c == CMD_RESET) begin
            state_d      = BUSY_RST;
            cnt_d        = '0;
            rb_d         = 1'b0;
            last_abort_d = 1'b1;
          end else begin
            state_d      = IDLE;
            last_abort_d = 1'b1;
          end
        end
      end
      default: begin
        if (is_cmd_c && bus_c == CMD_RESET) begin
          state_d = BUSY_RST;
          cnt_d   = '0;
        end else if (cnt_q == t_last_c) begin
          cnt_d = '0;
          rb_d  = 1'b1;
          if (state_q == BUSY_READ) begin
            load_c  = 1'b1;
            state_d = DATA_OUT;
          end else begin
            commit_c = (state_q == BUSY_PROG);
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Read-side output: drive only after an F_REN fall in an output state.
  always_comb begin
    io_oe_d   = (state_d == DATA_OUT || state_d == STATUS) && !F_REN && (io_oe_q || rfall_c);
    io_dout_d = (state_d == STATUS) ? status_c : buf_rd_c;
  end

  // Datapath, strobe history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      addr_hi_q    <= 1'b0;
      prog_q       <= 1'b0;
      last_abort_q <= 1'b0;
      F_RB         <= 1'b1;
      wen_q        <= 1'b1;
      ren_q        <= 1'b1;
      io_oe_q      <= 1'b0;
      io_dout_q    <= 8'h00;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      addr_hi_q    <= addr_hi_d;
      prog_q       <= prog_d;
      last_abort_q <= last_abort_d;
      F_RB         <= rb_d;
      wen_q        <= F_WEN;
      ren_q        <= F_REN;
      io_oe_q      <= io_oe_d;
      io_dout_q    <= io_dout_d;
    end
  end

  nand_page_array #(
    .PAGE_BYTES (PAGE_BYTES),
    .PAGES      (PAGES)
  ) u_array (
    .clk       (clk),
    .load      (load_c),
    .commit    (commit_c),
    .row       (row_q),
    .wr_en     (buf_we_c),
    .wr_col    (col_q),
    .wr_data   (bus_c),
    .rd_col    (col_d),
    .rd_data_c (buf_rd_c)
  );

  assign F_IO = io_oe_q ? io_dout_q : 8'bz;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder; F_IO is pulled down so an
// undriven bus reads 0x00.
`timescale 1ns/1ps
module tb_nand_flash_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       F_CLE = 1'b0, F_ALE = 1'b0, F_REN = 1'b1, F_WEN = 1'b1;
  logic [7:0] host_io = 8'h00;
  logic       host_oe = 1'b0;
  wire        F_RB;
  wire  [7:0] F_IO;
  int         checks = 0;
  int         passed = 0;

  assign F_IO = host_oe ? host_io : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pd
    pulldown (F_IO[i]);
  end

  always #5 clk = ~clk;

  nand_flash_responder dut (
    .clk   (clk),
    .rst   (rst),
    .F_IO  (F_IO),
    .F_CLE (F_CLE),
    .F_ALE (F_ALE),
    .F_REN (F_REN),
    .F_WEN (F_WEN),
    .F_RB  (F_RB)
  );

  // One write-enable pulse carrying a command/address/data byte.
  task automatic wr(input logic cle, input logic ale, input logic [7:0] b);
    @(negedge clk);
    F_CLE = cle; F_ALE = ale; host_io = b; host_oe = 1'b1; F_WEN = 1'b0;
    @(negedge clk);
    F_WEN = 1'b1;
    @(negedge clk);
    host_oe = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
  endtask

  task automatic rd(output logic [7:0] b);
    @(negedge clk);
    F_REN = 1'b0;
    @(negedge clk);
    b = F_IO;
    F_REN = 1'b1;
    @(negedge clk);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (F_RB === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    F_REN = 1'b0;
    @(negedge clk);
    checks++;
    if (F_RB !== 1'b1) $display("FAIL reset_rb: got %b expected 1", F_RB); else passed++;
    checks++;
    if (F_IO !== 8'h00) $display("FAIL reset_io_z: got %h expected 00", F_IO); else passed++;
    F_REN = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_program;
    int n;
    wr(1, 0, 8'h80); wr(0, 1, 8'h00); wr(0, 1, 8'h05);
    for (int i = 0; i < 4; i++) wr(0, 0, 8'hA0 + 8'(i));
    wr(1, 0, 8'h10);
    busy_len(n);
    checks++;
    if (n != 16) $display("FAIL prog_busy_len: got %0d expected 16", n); else passed++;
    checks++;
    if (F_RB !== 1'b1) $display("FAIL prog_rb_after: got %b expected 1", F_RB); else passed++;
  endtask

  task automatic test_readback;
    int n;
    logic [7:0] b;
    logic [7:0] exp [4] = '{8'hA2, 8'hA3, 8'hFF, 8'hFF};
    wr(1, 0, 8'h00); wr(0, 1, 8'h02); wr(0, 1, 8'h05);
    busy_len(n);
    checks++;
    if (n != 8) $display("FAIL read_busy_len: got %0d expected 8", n); else passed++;
    for (int i = 0; i < 4; i++) begin
      rd(b);
      checks++;
      if (b !== exp[i]) $display("FAIL readback[%0d]: got %h expected %h", i, b, exp[i]); else passed++;
    end
  endtask

  task automatic test_full_page;
    int n;
    logic [7:0] b, e;
    wr(1, 0, 8'h00); wr(0, 1, 8'h00); wr(0, 1, 8'h05);
    busy_len(n);
    checks++;
    if (n != 8) $display("FAIL page_busy_len: got %0d expected 8", n); else passed++;
    for (int i = 0; i < 32; i++) begin
      e = (i < 4) ? 8'hA0 + 8'(i) : 8'hFF;
      rd(b);
      checks++;
      if (b !== e) $display("FAIL page5[%0d]: got %h expected %h", i, b, e); else passed++;
    end
  endtask

  // Address bytes 0x3F/0x45 reduce to column 31, page 5.
  task automatic test_wrap;
    int n;
    logic [7:0] b;
    wr(1, 0, 8'h00); wr(0, 1, 8'h3F); wr(0, 1, 8'h45);
    busy_len(n);
    checks++;
    if (n != 8) $display("FAIL wrap_busy_len: got %0d expected 8", n); else passed++;
    rd(b);
    checks++;
    if (b !== 8'hFF) $display("FAIL wrap_col31: got %h expected ff", b); else passed++;
    rd(b);
    checks++;
    if (b !== 8'hA0) $display("FAIL wrap_col0: got %h expected a0", b); else passed++;
  endtask

  task automatic test_busy_read_z;
    int n;
    logic [7:0] b;
    wr(1, 0, 8'h00); wr(0, 1, 8'h01); wr(0, 1, 8'h05);
    F_REN = 1'b0;
    @(negedge clk);
    checks++;
    if (F_IO !== 8'h00) $display("FAIL busy_io_z: got %h expected 00", F_IO); else passed++;
    checks++;
    if (F_RB !== 1'b0) $display("FAIL busy_rb_low: got %b expected 0", F_RB); else passed++;
    F_REN = 1'b1;
    busy_len(n);
    checks++;
    if (F_RB !== 1'b1) $display("FAIL busy_read_done: got %b expected 1 after %0d", F_RB, n); else passed++;
    rd(b);
    checks++;
    if (b !== 8'hA1) $display("FAIL busy_read_col1: got %h expected a1", b); else passed++;
  endtask

  task automatic test_busy_ignore;
    int n;
    logic [7:0] b;
    wr(1, 0, 8'h80); wr(0, 1, 8'h00); wr(0, 1, 8'h07);
    wr(0, 0, 8'h55);
    wr(1, 0, 8'h10);
    repeat (2) @(negedge clk);
    wr(1, 0, 8'h00);
    checks++;
    if (F_RB !== 1'b0) $display("FAIL ignore_rb_low: got %b expected 0", F_RB); else passed++;
    wr(1, 0, 8'hFF);
    busy_len(n);
    checks++;
    if (n != 4) $display("FAIL rst_cmd_busy_len: got %0d expected 4", n); else passed++;
    wr(1, 0, 8'h00); wr(0, 1, 8'h00); wr(0, 1, 8'h07);
    busy_len(n);
    rd(b);
    checks++;
    if (b !== 8'hFF) $display("FAIL page7_unprogrammed: got %h expected ff", b); else passed++;
  endtask

  task automatic test_abort;
    int n;
    logic [7:0] b, e;
    wr(1, 0, 8'h80); wr(0, 1, 8'h00); wr(0, 1, 8'h06);
    wr(0, 0, 8'h11);
    wr(1, 0, 8'h00);
    checks++;
    if (F_RB !== 1'b1) $display("FAIL abort_rb: got %b expected 1", F_RB); else passed++;
    wr(1, 0, 8'h70);
    F_REN = 1'b0;
    @(negedge clk);
`ifdef NAND_STATUS_CMD_EN
    e = 8'hC2;
`else
    e = 8'h00;
`endif
    checks++;
    if (F_IO !== e) $display("FAIL status_byte: got %h expected %h", F_IO, e); else passed++;
    F_REN = 1'b1;
    @(negedge clk);
    wr(1, 0, 8'h00); wr(0, 1, 8'h00); wr(0, 1, 8'h06);
    busy_len(n);
    rd(b);
    checks++;
    if (b !== 8'hFF) $display("FAIL page6_after_abort: got %h expected ff", b); else passed++;
  endtask

  task automatic test_reset_mid_prog;
    int n;
    logic [7:0] b;
    wr(1, 0, 8'h80); wr(0, 1, 8'h00); wr(0, 1, 8'h08);
    wr(0, 0, 8'h5A);
    wr(1, 0, 8'h10);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    F_REN = 1'b0;
    @(negedge clk);
    checks++;
    if (F_RB !== 1'b1) $display("FAIL midrst_rb: got %b expected 1", F_RB); else passed++;
    checks++;
    if (F_IO !== 8'h00) $display("FAIL midrst_io_z: got %h expected 00", F_IO); else passed++;
    rst = 1'b0;
    F_REN = 1'b1;
    repeat (2) @(negedge clk);
    wr(1, 0, 8'h00); wr(0, 1, 8'h00); wr(0, 1, 8'h08);
    busy_len(n);
    rd(b);
    checks++;
    if (b !== 8'hFF) $display("FAIL page8_unchanged: got %h expected ff", b); else passed++;
  endtask

  initial begin
    test_reset();
    test_program();
    test_readback();
    test_full_page();
    test_wrap();
    test_busy_read_z();
    test_busy_ignore();
    test_abort();
    test_reset_mid_prog();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/nand_flash_responder.md
NAND_FLASH_RESPONDER -- requirements
Module: nand_flash_responder

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: PAGE_BYTES, 32, bytes per page; PAGES, 64, pages in array; T_READ, 8, busy cycles for array-to-buffer load; T_PROG, 16, busy cycles for buffer-to-array program; T_RST, 4, busy cycles for reset command.
REQ-002 Ports SHALL be: clk input 1, rising-edge clock; rst input 1, reset (asynchronous, active-high); F_IO inout 8, command/address/data bus; F_CLE input 1, command latch enable; F_ALE input 1, address latch enable; F_REN input 1, read enable (active-low); F_WEN input 1, write enable (latch on rising edge); F_RB output 1, ready(1)/busy(0).

Function
REQ-003 Write strobe SHALL be detected as F_WEN sampled 0 on the previous clk and 1 on the current clk; read strobe as F_REN 1->0 (drive), with 0->1 advancing the byte pointer.
REQ-004 On a write strobe: CLE=1,ALE=0 -> command byte; CLE=0,ALE=1 -> address byte; CLE=0,ALE=0 -> data byte; CLE=1,ALE=1 -> ignored.
REQ-005 FSM states SHALL be IDLE, ADDR, DATA_IN, BUSY_READ, BUSY_PROG, BUSY_RST, DATA_OUT, STATUS.
REQ-006 Command 0x00 in IDLE/DATA_OUT/STATUS -> ADDR (read flavour); 0x80 -> ADDR (program flavour); 0xFF from any state -> BUSY_RST; unknown opcodes ignored.
REQ-007 ADDR SHALL take exactly two address bytes: first -> column = byte mod PAGE_BYTES, second -> row = byte mod PAGES; then read flavour -> BUSY_READ, program flavour -> DATA_IN.
REQ-008 BUSY_* states SHALL hold F_RB=0 for exactly T_READ/T_PROG/T_RST clk cycles, F_RB rising on the clk that exits to DATA_OUT/IDLE/IDLE respectively.
REQ-009 BUSY_READ SHALL copy array page[row] into the page buffer; BUSY_PROG SHALL overwrite array page[row] with the page buffer.
REQ-010 DATA_IN data bytes SHALL write buffer[column], column increments and wraps PAGE_BYTES-1 -> 0; command 0x10 -> BUSY_PROG; any other command in DATA_IN aborts to IDLE without programming (0xFF -> BUSY_RST).
REQ-011 DATA_OUT SHALL drive F_IO = buffer[column] while F_REN=0; column increments on F_REN rising edge, wrapping to 0.
REQ-012 F_IO SHALL be high-Z except while F_REN=0 in DATA_OUT or STATUS.
REQ-013 While busy, all write strobes except command 0xFF SHALL be ignored; F_REN low in busy leaves F_IO high-Z.
REQ-014 Strobe of both F_WEN and F_REN in one cycle: write strobe processed, read strobe ignored.

Reset
REQ-015 rst SHALL force state IDLE, F_RB=1, F_IO high-Z, column=0, row=0, busy counter=0; array and page buffer contents SHALL be unaffected (array initialised to 0xFF at time zero only).
REQ-016 rst asserted mid-BUSY_PROG SHALL abandon programming; page[row] keeps its pre-program contents.

Configuration
REQ-017 With NAND_STATUS_CMD_EN defined, command 0x70 (not busy) -> STATUS, driving {F_RB, 1'b1, 4'b0, last_abort, 1'b0} while F_REN=0, where last_abort=1 if the previous program was aborted; exit on next command. Without it, 0x70 is an unknown opcode and ignored.

Structure
REQ-018 Package nand_pkg SHALL hold opcode constants (CMD_READ=0x00, CMD_PROG=0x80, CMD_PROG_CONF=0x10, CMD_STATUS=0x70, CMD_RESET=0xFF) and the FSM state enum.
REQ-019 Storage SHALL be a sub-module nand_page_array (PAGES x PAGE_BYTES byte array plus page buffer, page copy engine stepped by the busy counter); the FSM and bus logic stay in the top.

Verification
REQ-020 Program: 0x80, addr 0x00, 0x05, data 0xA0..0xA3, 0x10 -> F_RB low exactly 16 cycles; page 5 bytes 0..3 = 0xA0..0xA3, bytes 4..31 = 0xFF.
REQ-021 Read-back: 0x00, addr 0x02, 0x05 -> F_RB low 8 cycles; four F_REN pulses return 0xA2, 0xA3, 0xFF, 0xFF.
REQ-022 Wrap: read column 31 of page 5, two F_REN pulses -> 0xFF then 0xA0 (column 0).
REQ-023 Busy ignore/reset: during BUSY_PROG issue 0x00 -> ignored, F_RB stays low; issue 0xFF -> F_RB low 4 cycles then IDLE.
REQ-024 Abort: 0x80, addr 0,6, data 0x11, command 0x00 -> no program; page 6 byte 0 stays 0xFF; with NAND_STATUS_CMD_EN, 0x70 then F_REN low -> F_IO=0xC2.
REQ-025 Reset mid-program: assert rst 5 cycles into BUSY_PROG -> F_RB=1, F_IO high-Z next cycle, target page unchanged.
